// File: rtl/iir_coeff_sequencer.sv
// Shadow/active coefficient bank for the 2nd-order IIR filter with an atomic
// commit, an optional delay-line flush, and output muting while the filter settles.
module iir_coeff_sequencer #(
  parameter int unsigned COEFF_WIDTH    = 32,
  parameter int unsigned OUT_DATA_WIDTH = 16,
  parameter int unsigned FLUSH_CYCLES   = 8,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter logic [COEFF_WIDTH-1:0] B0_DEFAULT   = COEFF_WIDTH'(32'h4000_0000),
  parameter logic [COEFF_WIDTH-1:0] GAIN_DEFAULT = COEFF_WIDTH'(32'h0001_0000)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [2:0]                wr_addr,
  input  logic [COEFF_WIDTH-1:0]    wr_data,
  input  logic                      commit,
  input  logic                      flush_en,
  input  logic [OUT_DATA_WIDTH-1:0] y_in,
  output logic [COEFF_WIDTH-1:0]    b0,
  output logic [COEFF_WIDTH-1:0]    b1,
  output logic [COEFF_WIDTH-1:0]    b2,
  output logic [COEFF_WIDTH-1:0]    a1,
  output logic [COEFF_WIDTH-1:0]    a2,
  output logic [COEFF_WIDTH-1:0]    gain,
  output logic                      filt_rst,
  output logic [OUT_DATA_WIDTH-1:0] y_out,
  output logic                      busy,
  output logic                      commit_done,
  output logic                      wr_err,
  output logic                      commit_ovf
);

  localparam int unsigned NUM_COEFFS = 6;
  localparam int unsigned CNT_MAX    = (FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [COEFF_WIDTH-1:0] shadow_q [NUM_COEFFS];
  logic [COEFF_WIDTH-1:0] shadow_d [NUM_COEFFS];
  logic                   filt_rst_d, busy_d, done_d, ovf_d, wr_err_d, load_c;

  function automatic logic [COEFF_WIDTH-1:0] coeff_default(input int unsigned idx);
    if (idx == 0)      return B0_DEFAULT;
    else if (idx == 5) return GAIN_DEFAULT;
    else               return '0;
  endfunction

  // Shadow bank with this cycle's write merged in, so a same-cycle commit sees it
  always_comb begin
    wr_err_d = 1'b0;
    for (int i = 0; i < NUM_COEFFS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (wr_en && (wr_addr == 3'(i))) shadow_d[i] = wr_data;
    end
    if (wr_en && (wr_addr >= 3'(NUM_COEFFS))) wr_err_d = 1'b1;
  end

  // Sequence control: next state, counter and registered-output next values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    filt_rst_d = filt_rst;
    busy_d     = busy;
    done_d     = 1'b0;
    ovf_d      = 1'b0;
    load_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit) begin
          load_c = 1'b1;
          busy_d = 1'b1;
          if (flush_en) begin
            state_d    = FLUSH;
            filt_rst_d = 1'b1;
            cnt_d      = CNT_W'(FLUSH_CYCLES - 1);
          end else begin
            state_d = SETTLE;
            cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          end
        end
      end
      FLUSH: begin
        ovf_d = commit;
        if (cnt_q == '0) begin
          state_d    = SETTLE;
          filt_rst_d = 1'b0;
          cnt_d      = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SETTLE: begin
        ovf_d = commit;
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        filt_rst_d = 1'b0;
      end
    endcase
  end

  // Mute tracks busy exactly, so gate with busy's next value
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      filt_rst    <= 1'b0;
      busy        <= 1'b0;
      commit_done <= 1'b0;
      wr_err      <= 1'b0;
      commit_ovf  <= 1'b0;
      y_out       <= '0;
      for (int i = 0; i < NUM_COEFFS; i++) shadow_q[i] <= coeff_default(i);
      b0   <= B0_DEFAULT;
      b1   <= '0;
      b2   <= '0;
      a1   <= '0;
      a2   <= '0;
      gain <= GAIN_DEFAULT;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      filt_rst    <= filt_rst_d;
      busy        <= busy_d;
      commit_done <= done_d;
      wr_err      <= wr_err_d;
      commit_ovf  <= ovf_d;
      y_out       <= busy_d ? '0 : y_in;
      for (int i = 0; i < NUM_COEFFS; i++) shadow_q[i] <= shadow_d[i];
      if (load_c) begin
        b0   <= shadow_d[0];
        b1   <= shadow_d[1];
        b2   <= shadow_d[2];
        a1   <= shadow_d[3];
        a2   <= shadow_d[4];
        gain <= shadow_d[5];
      end
    end
  end

endmodule

// File: tb/tb_iir_coeff_sequencer.sv
// Bench for iir_coeff_sequencer: cycle-schedule model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_iir_coeff_sequencer;

  localparam int unsigned CW = 32;
  localparam int unsigned DW = 16;
  localparam int unsigned F  = 8;
  localparam int unsigned S  = 16;

  logic          clk = 1'b0;
  logic          rst, wr_en, commit, flush_en;
  logic [2:0]    wr_addr;
  logic [CW-1:0] wr_data;
  logic [DW-1:0] y_in;
  logic [CW-1:0] b0, b1, b2, a1, a2, gain;
  logic          filt_rst, busy, commit_done, wr_err, commit_ovf;
  logic [DW-1:0] y_out;

  int n_vec = 0;
  int n_err = 0;

  iir_coeff_sequencer #(
    .COEFF_WIDTH(CW), .OUT_DATA_WIDTH(DW), .FLUSH_CYCLES(F), .SETTLE_CYCLES(S),
    .B0_DEFAULT(32'h4000_0000), .GAIN_DEFAULT(32'h0001_0000)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .flush_en(flush_en), .y_in(y_in),
    .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2), .gain(gain),
    .filt_rst(filt_rst), .y_out(y_out), .busy(busy), .commit_done(commit_done),
    .wr_err(wr_err), .commit_ovf(commit_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a commit accepted in cycle c schedules absolute cycle windows
  // for filt_rst and busy starting at c+1; everything else follows from those.
  logic          model_ok = 1'b0;
  int            cyc = 0;
  int            seq_end = 0;
  int            flush_end = 0;
  logic          bz;
  logic [CW-1:0] m_sh  [6];
  logic [CW-1:0] m_act [6];
  logic          e_done, e_err, e_ovf;
  logic [DW-1:0] e_y;

  always @(posedge clk) begin
    bz = (cyc < seq_end);
    if (rst) begin
      model_ok = 1'b1;
      for (int i = 0; i < 6; i++) m_sh[i] = '0;
      m_sh[0] = 32'h4000_0000;
      m_sh[5] = 32'h0001_0000;
      m_act = m_sh;
      seq_end = 0;
      flush_end = 0;
      e_done = 1'b0; e_err = 1'b0; e_ovf = 1'b0; e_y = '0;
    end else begin
      e_done = (cyc + 1 == seq_end);
      e_ovf  = commit && bz;
      e_err  = wr_en && (wr_addr >= 3'd6);
      if (wr_en && wr_addr < 3'd6) m_sh[wr_addr] = wr_data;
      if (commit && !bz) begin
        m_act     = m_sh;
        flush_end = cyc + 1 + (flush_en ? int'(F) : 0);
        seq_end   = flush_end + int'(S);
      end
      e_y = (cyc + 1 < seq_end) ? '0 : y_in;
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("b0", b0, m_act[0]);
      check("b1", b1, m_act[1]);
      check("b2", b2, m_act[2]);
      check("a1", a1, m_act[3]);
      check("a2", a2, m_act[4]);
      check("gain", gain, m_act[5]);
      check("filt_rst", 32'(filt_rst), 32'(cyc < flush_end));
      check("busy", 32'(busy), 32'(cyc < seq_end));
      check("commit_done", 32'(commit_done), 32'(e_done));
      check("wr_err", 32'(wr_err), 32'(e_err));
      check("commit_ovf", 32'(commit_ovf), 32'(e_ovf));
      check("y_out", 32'(y_out), 32'(e_y));
    end
  end

  initial begin
    y_in = '0;
    forever begin
      @(posedge clk);
      #2;
      y_in = DW'($urandom);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    wr_en = 1'b0; commit = 1'b0; flush_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_addr = '0; wr_data = '0;
    quiet();
    tick(); tick();
    @(negedge clk);
    check("rst_b0", b0, 32'h4000_0000);
    check("rst_gain", gain, 32'h0001_0000);
    check("rst_b1", b1, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_y", 32'(y_out), 32'h0);
    tick(); rst = 1'b0;
    tick(); tick();

    // Flushing commit: write b1 at c0, commit at c2
    tick(); wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'h1234_5678;
    tick(); quiet();
    tick(); commit = 1'b1; flush_en = 1'b1;
    tick(); quiet();
    @(negedge clk);
    check("t1_b1", b1, 32'h1234_5678);
    check("t1_filt_c3", 32'(filt_rst), 32'h1);
    check("t1_y_c3", 32'(y_out), 32'h0);
    repeat (7) tick();
    @(negedge clk);
    check("t1_filt_c10", 32'(filt_rst), 32'h1);
    tick();
    @(negedge clk);
    check("t1_filt_c11", 32'(filt_rst), 32'h0);
    repeat (15) tick();
    @(negedge clk);
    check("t1_busy_c26", 32'(busy), 32'h1);
    check("t1_y_c26", 32'(y_out), 32'h0);
    tick();
    @(negedge clk);
    check("t1_done_c27", 32'(commit_done), 32'h1);
    check("t1_busy_c27", 32'(busy), 32'h0);
    repeat (3) tick();

    // Same-cycle write bypass into a non-flushing commit
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hFFFF_0000; commit = 1'b1;
    tick(); quiet();
    @(negedge clk);
    check("t2_a1", a1, 32'hFFFF_0000);
    check("t2_filt", 32'(filt_rst), 32'h0);
    repeat (15) tick();
    @(negedge clk);
    check("t2_busy_c16", 32'(busy), 32'h1);
    tick();
    @(negedge clk);
    check("t2_done_c17", 32'(commit_done), 32'h1);
    repeat (2) tick();

    // Overflow: commit during SETTLE must not apply the newer shadow b0
    commit = 1'b1;
    tick(); quiet();
    tick(); tick();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h1111_1111;
    tick(); quiet();
    tick(); commit = 1'b1;
    tick(); quiet();
    @(negedge clk);
    check("t3_ovf", 32'(commit_ovf), 32'h1);
    check("t3_b0", b0, 32'h4000_0000);
    repeat (11) tick();
    @(negedge clk);
    check("t3_done_c17", 32'(commit_done), 32'h1);
    repeat (2) tick();

    // Invalid address, then commit to expose the shadow contents
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 32'hDEAD_BEEF;
    tick(); quiet();
    @(negedge clk);
    check("t4_err", 32'(wr_err), 32'h1);
    tick(); commit = 1'b1;
    @(negedge clk);
    check("t4_err_clr", 32'(wr_err), 32'h0);
    tick(); quiet();
    @(negedge clk);
    check("t4_b0", b0, 32'h1111_1111);
    check("t4_a2", a2, 32'h0);
    check("t4_gain", gain, 32'h0001_0000);
    repeat (18) tick();

    // Mid-flush reset at FLUSH cycle 4
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h0000_00AB;
    commit = 1'b1; flush_en = 1'b1;
    tick(); quiet();
    tick(); tick(); tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    check("t5_filt", 32'(filt_rst), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_b0", b0, 32'h4000_0000);
    check("t5_b2", b2, 32'h0);
    repeat (30) tick();

    // Commit held high across completion
    commit = 1'b1;
    repeat (20) tick();
    quiet();
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
